// File: rtl/eco32f_div_ctrl.sv
// eco32f_div_ctrl: sequencer for the iterative 32-bit divide/remainder unit
// in the execute stage. It runs a radix-2 restoring divide over 32 cycles on
// operand magnitudes, applies the signed fix-up, and returns the quotient or
// the remainder.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ex_op_div/ex_op_rem DIV-class / REM-class op present in EX
//   ex_signed_div      operands and result are two's complement
//   ex_flush           kill the EX instruction (aborts any divide in flight)
//   ex_stall_ext       stall from other stages; holds the DONE result
//   ex_x, ex_y         dividend, divisor
//   div_stall          EX must hold while the divide is in progress
//   div_valid          div_result valid this cycle
//   div_result         quotient (div) or remainder (rem)
//   exc_div_zero       divide-by-zero exception
//
// Build option: define ECO32F_DIV_ZERO_EXC_EN to make a zero divisor finish
// immediately with div_result=0 and exc_div_zero=1. Without it, a zero
// divisor runs the full iteration and exc_div_zero is tied low.
module eco32f_div_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_op_div,
  input  logic        ex_op_rem,
  input  logic        ex_signed_div,
  input  logic        ex_flush,
  input  logic        ex_stall_ext,
  input  logic [31:0] ex_x,
  input  logic [31:0] ex_y,
  output logic        div_stall,
  output logic        div_valid,
  output logic [31:0] div_result,
  output logic        exc_div_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] x_q, x_d;        // original dividend
  logic [31:0] b_q, b_d;        // divisor, replaced by its magnitude in PREP
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic [31:0] result_q, result_d;
  logic        sx_q, sx_d;
  logic        sy_q, sy_d;
  logic        rem_q, rem_d;
`ifdef ECO32F_DIV_ZERO_EXC_EN
  logic        exc_q, exc_d;
`endif

  logic        start;
  logic [32:0] r_sh;
  logic [32:0] diff;
  logic        fits;

  assign start = (ex_op_div | ex_op_rem) & (state_q == S_IDLE) & ~ex_flush;

  // One restoring step. r stays below b (< 2^32), so the shifted partial
  // remainder fits in 33 bits and bit 32 of the difference is the borrow.
  assign r_sh = {r_q, q_q[31]};
  assign diff = r_sh - {1'b0, b_q};
  assign fits = ~diff[32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    b_d      = b_q;
    q_d      = q_q;
    r_d      = r_q;
    result_d = result_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    rem_d    = rem_q;
`ifdef ECO32F_DIV_ZERO_EXC_EN
    exc_d    = exc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREP;
          x_d     = ex_x;
          b_d     = ex_y;
          sx_d    = ex_x[31] & ex_signed_div;
          sy_d    = ex_y[31] & ex_signed_div;
          rem_d   = ex_op_rem;
        end
      end
      S_PREP: begin
        q_d   = sx_q ? -x_q : x_q;
        b_d   = sy_q ? -b_q : b_q;
        r_d   = '0;
        cnt_d = 5'd31;
`ifdef ECO32F_DIV_ZERO_EXC_EN
        if (b_d == '0) begin
          state_d  = S_DONE;
          result_d = '0;
          exc_d    = 1'b1;
        end else begin
          state_d = S_ITER;
        end
`else
        state_d = S_ITER;
`endif
      end
      S_ITER: begin
        r_d   = fits ? diff[31:0] : r_sh[31:0];
        q_d   = {q_q[30:0], fits};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FIX;
      end
      S_FIX: begin
`ifndef ECO32F_DIV_ZERO_EXC_EN
        // Zero divisor: iteration leaves q all ones; skip the sign fix-up
        // and hand back the untouched dividend as the remainder.
        if (b_q == '0)
          result_d = rem_q ? x_q : q_q;
        else
`endif
          result_d = rem_q ? (sx_q ? -r_q : r_q)
                           : ((sx_q ^ sy_q) ? -q_q : q_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!ex_stall_ext) begin
          state_d = S_IDLE;
`ifdef ECO32F_DIV_ZERO_EXC_EN
          exc_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over start and over the DONE hold.
    if (ex_flush) begin
      state_d = S_IDLE;
`ifdef ECO32F_DIV_ZERO_EXC_EN
      exc_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      rem_q    <= 1'b0;
`ifdef ECO32F_DIV_ZERO_EXC_EN
      exc_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      b_q      <= b_d;
      q_q      <= q_d;
      r_q      <= r_d;
      result_q <= result_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      rem_q    <= rem_d;
`ifdef ECO32F_DIV_ZERO_EXC_EN
      exc_q    <= exc_d;
`endif
    end
  end

  assign div_stall  = start | (state_q == S_PREP) | (state_q == S_ITER) |
                      (state_q == S_FIX);
  assign div_valid  = (state_q == S_DONE) & ~ex_flush;
  assign div_result = result_q;
`ifdef ECO32F_DIV_ZERO_EXC_EN
  assign exc_div_zero = exc_q & div_valid;
`else
  assign exc_div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_eco32f_div_ctrl.sv
// Self-checking bench for eco32f_div_ctrl. Expected results come from plain
// 64-bit integer division of the operands; latency and exception behaviour
// follow the cycle budget of the divide sequencer.
module tb_eco32f_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_op_div = 1'b0;
  logic        ex_op_rem = 1'b0;
  logic        ex_signed_div = 1'b0;
  logic        ex_flush = 1'b0;
  logic        ex_stall_ext = 1'b0;
  logic [31:0] ex_x = '0;
  logic [31:0] ex_y = '0;
  logic        div_stall;
  logic        div_valid;
  logic [31:0] div_result;
  logic        exc_div_zero;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  eco32f_div_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_op_div    (ex_op_div),
    .ex_op_rem    (ex_op_rem),
    .ex_signed_div(ex_signed_div),
    .ex_flush     (ex_flush),
    .ex_stall_ext (ex_stall_ext),
    .ex_x         (ex_x),
    .ex_y         (ex_y),
    .div_stall    (div_stall),
    .div_valid    (div_valid),
    .div_result   (div_result),
    .exc_div_zero (exc_div_zero)
  );

  always #5 clk = ~clk;

`ifdef ECO32F_DIV_ZERO_EXC_EN
  localparam bit ZEXC = 1'b1;
`else
  localparam bit ZEXC = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [31:0] x, input logic [31:0] y,
                                             input bit sgn, input bit rem);
    longint xs, ys, q, r;
    if (y == 32'd0) begin
      if (ZEXC) return 32'd0;
      return rem ? x : 32'hFFFF_FFFF;
    end
    xs = sgn ? longint'($signed(x)) : longint'(x);
    ys = sgn ? longint'($signed(y)) : longint'(y);
    q  = xs / ys;
    r  = xs % ys;
    return rem ? r[31:0] : q[31:0];
  endfunction

  // Issue one op at cycle 0 (caller sits just after a rising edge with the
  // unit idle), hold it in EX until the result has been consumed.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input bit sgn, input bit rem, input int hold);
    int cyc, stalls, exp_lat;
    logic [31:0] exp_res;
    logic        exp_exc;
    exp_res = ref_result(x, y, sgn, rem);
    exp_exc = ZEXC && (y == 32'd0);
    exp_lat = exp_exc ? 2 : 35;
    ex_x = x; ex_y = y; ex_signed_div = sgn;
    ex_op_div = !rem; ex_op_rem = rem;
    cyc = 0; stalls = 0;
    @(negedge clk);
    while (!div_valid && cyc < 40) begin
      if (div_stall) stalls++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "/latency"}, cyc, exp_lat);
    chk({tag, "/stall_cycles"}, stalls, exp_lat);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "/valid"}, {31'd0, div_valid}, 32'd1);
      chk({tag, "/result"}, div_result, exp_res);
      chk({tag, "/exc"}, {31'd0, exc_div_zero}, {31'd0, exp_exc});
      chk({tag, "/stall_done"}, {31'd0, div_stall}, 32'd0);
      ex_stall_ext = (i < hold);
      if (i == hold) begin
        ex_op_div = 1'b0;
        ex_op_rem = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "/valid_after"}, {31'd0, div_valid}, 32'd0);
    chk({tag, "/stall_after"}, {31'd0, div_stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset values.
    #2;
    chk("rst/stall", {31'd0, div_stall}, 32'd0);
    chk("rst/valid", {31'd0, div_valid}, 32'd0);
    chk("rst/result", div_result, 32'd0);
    chk("rst/exc", {31'd0, exc_div_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-divide traffic leaves the unit idle.
    for (int i = 0; i < 3; i++) begin
      ex_x = $urandom; ex_y = $urandom;
      @(negedge clk);
      chk("idle/stall", {31'd0, div_stall}, 32'd0);
      chk("idle/valid", {31'd0, div_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Directed cases.
    run_op("udiv", 32'd100, 32'd7, 1'b0, 1'b0, 0);
    run_op("urem", 32'd100, 32'd7, 1'b0, 1'b1, 0);
    run_op("sdiv_nx", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, 0);
    run_op("srem_nx", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 0);
    run_op("sdiv_ny", 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0, 0);
    run_op("srem_ny", 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1, 0);
    run_op("ovf_div", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("ovf_rem", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
    run_op("dz_div", 32'd5, 32'd0, 1'b0, 1'b0, 0);
    run_op("dz_rem", 32'd5, 32'd0, 1'b0, 1'b1, 0);
    run_op("dz_srem", 32'hFFFF_FFF0, 32'd0, 1'b1, 1'b1, 0);
    run_op("hold3", 32'd1000, 32'd33, 1'b0, 1'b0, 3);
    run_op("dz_hold", 32'd9, 32'd0, 1'b1, 1'b0, 2);

    // Flush at cycle 10 of a divide, then a fresh divide.
    ex_x = 32'd1000; ex_y = 32'd3; ex_signed_div = 1'b0;
    ex_op_div = 1'b1; ex_op_rem = 1'b0;
    repeat (10) @(posedge clk);
    #1 ex_flush = 1'b1;
    @(negedge clk);
    chk("flush/valid_c10", {31'd0, div_valid}, 32'd0);
    @(posedge clk); #1;
    ex_flush = 1'b0; ex_op_div = 1'b0;
    @(negedge clk);
    chk("flush/stall_c11", {31'd0, div_stall}, 32'd0);
    chk("flush/valid_c11", {31'd0, div_valid}, 32'd0);
    @(posedge clk); #1;
    run_op("post_flush", 32'd1000, 32'd3, 1'b0, 1'b0, 0);

    // Flush has priority over start in IDLE.
    ex_op_rem = 1'b1; ex_flush = 1'b1;
    @(negedge clk);
    chk("flush_start/stall", {31'd0, div_stall}, 32'd0);
    @(posedge clk); #1;
    ex_op_rem = 1'b0; ex_flush = 1'b0;
    @(negedge clk);
    chk("flush_start/no_run", {31'd0, div_stall}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation.
    ex_x = 32'd77; ex_y = 32'd5; ex_op_div = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0; ex_op_div = 1'b0;
    #1;
    chk("arst/stall", {31'd0, div_stall}, 32'd0);
    chk("arst/valid", {31'd0, div_valid}, 32'd0);
    chk("arst/result", div_result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("arst/idle", {31'd0, div_stall}, 32'd0);
    @(posedge clk); #1;

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] rx, ry;
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: ry = 32'd0;
        1: ry = $urandom_range(1, 15);
        2: ry = -($urandom_range(1, 15));
        default: ry = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rx, ry, bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
